// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a decoded instruction request (kind, register indices, funct3,
// funct7b5, byte immediate) into a 32-bit RV32I instruction word.
//
// The word is delivered through a single output register using a
// valid/ready handshake. Requests that cannot be encoded legally are still
// accepted. Instead of the requested instruction, they produce a NOP
// (addi x0,x0,0) with out_err raised.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : request present
//   in_ready   : encoder accepts the request this cycle
//   in_kind    : 0 lw, 1 sw, 2 R, 3 branch, 4 I-ALU, 5 jal, 6 lui,
//                7 auipc, 8 jalr; 9-15 illegal
//   rd/rs1/rs2 : register indices
//   funct3     : operation select (R, branch, I-ALU only)
//   funct7b5   : sub/sra select for R-type and I-ALU shifts
//   imm        : signed byte immediate (full 32-bit value for lui/auipc)
//   out_valid  : encoded word present
//   out_ready  : consumer takes the word
//   out_instr  : encoded instruction word
//   out_err    : current word is a substituted NOP
//   out_count  : words delivered, wraps at 16 bits
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] out_count
);

    localparam logic [3:0] KIND_LW     = 4'd0;
    localparam logic [3:0] KIND_SW     = 4'd1;
    localparam logic [3:0] KIND_R      = 4'd2;
    localparam logic [3:0] KIND_BRANCH = 4'd3;
    localparam logic [3:0] KIND_IALU   = 4'd4;
    localparam logic [3:0] KIND_JAL    = 4'd5;
    localparam logic [3:0] KIND_LUI    = 4'd6;
    localparam logic [3:0] KIND_AUIPC  = 4'd7;
    localparam logic [3:0] KIND_JALR   = 4'd8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        EMPTY,
        FULL
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic        transfer;
    logic [31:0] encWord;
    logic        encLegal;
    logic        immInI;
    logic        immInB;
    logic        immInJ;
    logic        isShift;

    assign in_ready  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign transfer  = in_valid && in_ready;

    // Signed range checks on the immediate, shared by several formats.
    // I/S formats hold 12 signed bits, B holds 13 and J holds 21.
    // For B and J the lowest bit is implicit, so it must be zero.
    always_comb begin
        immInI  = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
        immInB  = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094)
                  && !imm[0];
        immInJ  = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574)
                  && !imm[0];
        isShift = (funct3 == 3'b001) || (funct3 == 3'b101);
    end

    // Field packing for every kind, together with its legality verdict.
    // Shift immediates carry the shift amount in imm[4:0]. The upper
    // immediate bits are then rebuilt from funct7b5, so srai/srli/slli
    // take their variant from the same select as the R-type sub/sra.
    always_comb begin
        encWord  = 32'h0;
        encLegal = 1'b0;
        case (in_kind)
            KIND_LW: begin
                encWord  = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
                encLegal = immInI;
            end
            KIND_SW: begin
                encWord  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
                encLegal = immInI;
            end
            KIND_R: begin
                encWord  = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_REG};
                encLegal = 1'b1;
            end
            KIND_BRANCH: begin
                encWord  = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], OP_BRANCH};
                encLegal = immInB && (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            KIND_IALU: begin
                if (isShift) begin
                    encWord  = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3,
                                rd, OP_IMM};
                    encLegal = (imm[31:5] == 27'd0);
                end else begin
                    encWord  = {imm[11:0], rs1, funct3, rd, OP_IMM};
                    encLegal = immInI;
                end
            end
            KIND_JAL: begin
                encWord  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                encLegal = immInJ;
            end
            KIND_LUI: begin
                encWord  = {imm[31:12], rd, OP_LUI};
                encLegal = (imm[11:0] == 12'd0);
            end
            KIND_AUIPC: begin
                encWord  = {imm[31:12], rd, OP_AUIPC};
                encLegal = (imm[11:0] == 12'd0);
            end
            KIND_JALR: begin
                encWord  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                encLegal = immInI;
            end
            default: begin
                encWord  = 32'h0;
                encLegal = 1'b0;
            end
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // The stage fills on any accepted request.
    // It drains only when the consumer takes the word and no replacement
    // arrives in the same cycle.
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: begin
                if (transfer) begin
                    stateNext = FULL;
                end
            end
            FULL: begin
                if (out_ready && !transfer) begin
                    stateNext = EMPTY;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
    end

    // The word register loads only on a transfer.
    // Because of this, the held word cannot change while the consumer
    // stalls. Illegal requests still occupy a slot, carrying the NOP word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else if (transfer) begin
            out_instr <= encLegal ? encWord : NOP_WORD;
            out_err   <= !encLegal;
        end
    end

    // Delivered-word counter. It counts every completed output handshake,
    // including error words, and wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_count <= 16'h0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder.
//
// Each request is pushed onto a scoreboard along with its hand-encoded
// expected word at the moment it is accepted. A monitor pops the
// scoreboard on every output handshake and compares the result.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] out_count;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        string       tag;
    } expT;

    expT sb[$];
    expT monE;
    int  total = 0;
    int  bad = 0;
    int  expCount = 0;
    int  waited;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_count (out_count)
    );

    // One counted comparison. A failure reports the tag, the observed
    // value and the required value.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request starting at a falling edge and hold it until it is
    // accepted, or until the wait limit expires. The request is then
    // recorded on the scoreboard and the task returns just after the
    // accepting rising edge.
    task automatic applyStimulus(input logic [3:0] kind, input logic [4:0] rdV,
                                 input logic [4:0] rs1V, input logic [4:0] rs2V,
                                 input logic [2:0] f3V, input logic f7V,
                                 input logic [31:0] immV, input logic [31:0] expInstr,
                                 input logic expErr, input string tag,
                                 output int waitCycles);
        expT e;
        @(negedge clk);
        in_kind  = kind;
        rd       = rdV;
        rs1      = rs1V;
        rs2      = rs2V;
        funct3   = f3V;
        funct7b5 = f7V;
        imm      = immV;
        in_valid = 1'b1;
        waitCycles = 0;
        #1;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        checkOutput({tag, ".accept"}, 32'(in_ready), 32'd1);
        if (in_ready) begin
            e.instr = expInstr;
            e.err   = expErr;
            e.tag   = tag;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor. This samples well after the falling edge, when
    // inputs changed at that edge have settled. A handshake seen here
    // completes at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            checkOutput("sbHasEntry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                monE = sb.pop_front();
                checkOutput({monE.tag, ".instr"}, out_instr, monE.instr);
                checkOutput({monE.tag, ".err"}, 32'(out_err), 32'(monE.err));
            end
            expCount++;
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_kind   = 4'd0;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        imm       = 32'd0;

        // Hold reset with a live request.
        // Nothing may register, and in_ready must read high even though the
        // consumer is not ready.
        in_valid = 1'b1;
        in_kind  = 4'd4;
        rd       = 5'd1;
        imm      = 32'd5;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("reset.valid", 32'(out_valid), 32'd0);
        checkOutput("reset.instr", out_instr, 32'd0);
        checkOutput("reset.err", 32'(out_err), 32'd0);
        checkOutput("reset.count", 32'(out_count), 32'd0);
        checkOutput("reset.inReady", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // addi x1,x0,5: must be accepted at the first edge and valid one
        // cycle later.
        applyStimulus(4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5,
                      32'h00500093, 1'b0, "addi", waited);
        checkOutput("firstAccept.wait", 32'(waited), 32'd0);
        checkOutput("latency.valid", 32'(out_valid), 32'd1);
        checkOutput("latency.instr", out_instr, 32'h00500093);

        // Legal encodings across all formats, including range edges.
        applyStimulus(4'd0, 5'd2, 5'd1, 5'd0, 3'b000, 1'b0, 32'd8,
                      32'h0080A103, 1'b0, "lw", waited);
        applyStimulus(4'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4,
                      32'hFE208EE3, 1'b0, "beq", waited);
        applyStimulus(4'd1, 5'd0, 5'd6, 5'd5, 3'b000, 1'b0, -32'sd2048,
                      32'h80532023, 1'b0, "swMin", waited);
        applyStimulus(4'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0,
                      32'h402081B3, 1'b0, "sub", waited);
        applyStimulus(4'd4, 5'd4, 5'd5, 5'd0, 3'b101, 1'b1, 32'd31,
                      32'h41F2D213, 1'b0, "srai31", waited);
        applyStimulus(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048,
                      32'h001000EF, 1'b0, "jal", waited);
        applyStimulus(4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000,
                      32'h123452B7, 1'b0, "lui", waited);
        applyStimulus(4'd8, 5'd0, 5'd1, 5'd0, 3'b000, 1'b0, 32'd0,
                      32'h00008067, 1'b0, "jalr", waited);
        applyStimulus(4'd3, 5'd0, 5'd1, 5'd2, 3'b001, 1'b0, 32'd4094,
                      32'h7E209FE3, 1'b0, "bneMax", waited);

        // Illegal requests each become the NOP word with the error flag set.
        applyStimulus(4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048,
                      32'h00000013, 1'b1, "addiRange", waited);
        applyStimulus(4'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3,
                      32'h00000013, 1'b1, "beqOdd", waited);
        applyStimulus(4'd4, 5'd1, 5'd1, 5'd0, 3'b001, 1'b0, 32'd32,
                      32'h00000013, 1'b1, "slli32", waited);
        applyStimulus(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1048576,
                      32'h00000013, 1'b1, "jalRange", waited);
        applyStimulus(4'd7, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h00001001,
                      32'h00000013, 1'b1, "auipcLow", waited);
        applyStimulus(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8,
                      32'h00000013, 1'b1, "branchF3", waited);
        applyStimulus(4'd9, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0,
                      32'h00000013, 1'b1, "kind9", waited);

        repeat (3) @(negedge clk);
        #3;
        checkOutput("count.afterDirected", 32'(out_count), 32'(expCount));
        checkOutput("sb.drainedDirected", 32'(sb.size()), 32'd0);

        // Three back-to-back requests while the consumer stalls.
        // The first word must hold steady with in_ready low. After release,
        // all three words must leave on consecutive cycles.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                int w1;
                applyStimulus(4'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 32'd0,
                              32'h003100B3, 1'b0, "add", w1);
                applyStimulus(4'd2, 5'd4, 5'd5, 5'd6, 3'b100, 1'b0, 32'd0,
                              32'h0062C233, 1'b0, "xor", w1);
                applyStimulus(4'd2, 5'd7, 5'd8, 5'd9, 3'b110, 1'b0, 32'd0,
                              32'h009463B3, 1'b0, "or", w1);
            end
            begin
                int w2;
                w2 = 0;
                @(negedge clk);
                #2;
                while (!out_valid && w2 < 20) begin
                    @(negedge clk);
                    #2;
                    w2++;
                end
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        #2;
                    end
                    checkOutput("stall.valid", 32'(out_valid), 32'd1);
                    checkOutput("stall.instr", out_instr, 32'h003100B3);
                    checkOutput("stall.err", 32'(out_err), 32'd0);
                    checkOutput("stall.inReady", 32'(in_ready), 32'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
                #2;
                checkOutput("burst.valid0", 32'(out_valid), 32'd1);
                @(negedge clk);
                #2;
                checkOutput("burst.valid1", 32'(out_valid), 32'd1);
                @(negedge clk);
                #2;
                checkOutput("burst.valid2", 32'(out_valid), 32'd1);
            end
        join

        repeat (3) @(negedge clk);
        #3;
        checkOutput("burst.emptyAfter", 32'(out_valid), 32'd0);
        checkOutput("count.afterBurst", 32'(out_count), 32'(expCount));
        checkOutput("sb.drainedBurst", 32'(sb.size()), 32'd0);

        // Hold a word, then pulse reset between edges.
        // The word is discarded uncounted, and the next request must
        // encode normally.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000,
                      32'h123452B7, 1'b0, "luiHeld", waited);
        @(negedge clk);
        #2;
        checkOutput("held.valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("pulse.valid", 32'(out_valid), 32'd0);
        checkOutput("pulse.count", 32'(out_count), 32'd0);
        checkOutput("pulse.instr", out_instr, 32'd0);
        checkOutput("pulse.inReady", 32'(in_ready), 32'd1);
        #1;
        reset_n = 1'b1;
        sb.delete();
        expCount = 0;
        out_ready = 1'b1;

        applyStimulus(4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5,
                      32'h00500093, 1'b0, "addiAfterPulse", waited);
        checkOutput("afterPulse.instr", out_instr, 32'h00500093);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("count.afterPulse", 32'(out_count), 32'(expCount));
        checkOutput("sb.drainedFinal", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
